sram_access_arbiter: RTL

// - Shares the single off-chip audio SRAM between the recorder write port and the player read port.
// - Runs one access at a time, each lasting ACCESS_CYCLES clocks.
// - Round-robin grant on conflict; fixed turnaround gap between accesses.
// - Sits between AudRecorder/AudPlayer and the SRAM pins in the audio top level.

---
 rtl/sram_access_arbiter.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/sram_access_arbiter.sv
// sram_access_arbiter
//   Shares one asynchronous audio SRAM between the recorder write port and the
//   player read port. One access runs at a time and lasts ACCESS_CYCLES clocks.
//   When both ports request together, round-robin decides the grant. At least
//   one idle cycle, with all strobes high, separates any two accesses. Every
//   output is registered.
//
// Parameters
//   ADDR_W         SRAM word address width
//   DATA_W         SRAM word width
//   ACCESS_CYCLES  clocks per access, 1..15
//
// Ports
//   i_clk, i_rst                  clock, synchronous active-high reset
//   i_wr_req/i_wr_addr/i_wr_data  recorder write request (level, held until ack)
//   o_wr_ack                      one-cycle pulse in the last write-access cycle
//   i_rd_req/i_rd_addr            player read request (level, held until ack)
//   o_rd_ack                      one-cycle pulse in the last read-access cycle
//   o_rd_data/o_rd_valid          captured read word; valid pulses the cycle after ack
//   o_sram_addr/o_sram_wdata      SRAM address and write data
//   o_sram_we_n/oe_n/ce_n         SRAM strobes, active-low
//   i_sram_rdata                  SRAM read data
//   o_busy                        high while a write or read access is running
//
// Optional build macro
//   SRAM_ARB_STATS_EN  adds o_conflicts[15:0]. This saturating counter records
//                      idle cycles in which both ports request and a grant is
//                      issued.

module sram_access_arbiter #(
  parameter int unsigned ADDR_W        = 20,
  parameter int unsigned DATA_W        = 16,
  parameter int unsigned ACCESS_CYCLES = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_wr_req,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic              o_wr_ack,
  input  logic              i_rd_req,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic              o_rd_ack,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_rd_valid,
  output logic [ADDR_W-1:0] o_sram_addr,
  output logic [DATA_W-1:0] o_sram_wdata,
  output logic              o_sram_we_n,
  output logic              o_sram_oe_n,
  output logic              o_sram_ce_n,
  input  logic [DATA_W-1:0] i_sram_rdata,
  output logic              o_busy
`ifdef SRAM_ARB_STATS_EN
  ,
  output logic [15:0]       o_conflicts
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_WR, S_RD} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES - 1);

  state_t              r_state, w_state;
  logic [3:0]          r_cnt, w_cnt;
  logic                r_last_rd, w_last_rd;
  logic [ADDR_W-1:0]   r_addr, w_addr;
  logic [DATA_W-1:0]   r_wdata, w_wdata;
  logic                r_we_n, w_we_n;
  logic                r_oe_n, w_oe_n;
  logic                r_ce_n, w_ce_n;
  logic                r_wr_ack, w_wr_ack;
  logic                r_rd_ack, w_rd_ack;
  logic [DATA_W-1:0]   r_rd_data, w_rd_data;
  logic                r_rd_valid, w_rd_valid;
  logic                r_busy, w_busy;
  logic                w_grant_wr, w_grant_rd;

  always_comb begin
    w_state    = r_state;
    w_cnt      = r_cnt;
    w_last_rd  = r_last_rd;
    w_addr     = r_addr;
    w_wdata    = r_wdata;
    w_we_n     = 1'b1;
    w_oe_n     = 1'b1;
    w_ce_n     = 1'b1;
    w_wr_ack   = 1'b0;
    w_rd_ack   = 1'b0;
    w_rd_data  = r_rd_data;
    w_rd_valid = 1'b0;
    w_busy     = 1'b0;
    w_grant_wr = 1'b0;
    w_grant_rd = 1'b0;

    case (r_state)
      S_IDLE: begin
        // On a conflict the write wins only if the read had the previous conflict grant.
        w_grant_wr = i_wr_req && (!i_rd_req || r_last_rd);
        w_grant_rd = i_rd_req && !w_grant_wr;
        if (i_wr_req && i_rd_req) w_last_rd = w_grant_rd;
        if (w_grant_wr) begin
          w_state  = S_WR;
          w_addr   = i_wr_addr;
          w_wdata  = i_wr_data;
          w_ce_n   = 1'b0;
          w_we_n   = 1'b0;
          w_cnt    = CNT_LOAD;
          w_wr_ack = (CNT_LOAD == 4'd0);
          w_busy   = 1'b1;
        end else if (w_grant_rd) begin
          w_state  = S_RD;
          w_addr   = i_rd_addr;
          w_ce_n   = 1'b0;
          w_oe_n   = 1'b0;
          w_cnt    = CNT_LOAD;
          w_rd_ack = (CNT_LOAD == 4'd0);
          w_busy   = 1'b1;
        end
      end
      S_WR, S_RD: begin
        if (r_cnt == 4'd0) begin
          w_state = S_IDLE;
          if (r_state == S_RD) begin
            w_rd_data  = i_sram_rdata;
            w_rd_valid = 1'b1;
          end
        end else begin
          // The acks are registered, so each one is raised one edge early,
          // when the final access cycle (cnt==0) is entered.
          w_cnt    = r_cnt - 4'd1;
          w_ce_n   = 1'b0;
          w_we_n   = r_we_n;
          w_oe_n   = r_oe_n;
          w_busy   = 1'b1;
          w_wr_ack = (r_state == S_WR) && (r_cnt == 4'd1);
          w_rd_ack = (r_state == S_RD) && (r_cnt == 4'd1);
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_last_rd  <= 1'b1;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_we_n     <= 1'b1;
      r_oe_n     <= 1'b1;
      r_ce_n     <= 1'b1;
      r_wr_ack   <= 1'b0;
      r_rd_ack   <= 1'b0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_cnt      <= w_cnt;
      r_last_rd  <= w_last_rd;
      r_addr     <= w_addr;
      r_wdata    <= w_wdata;
      r_we_n     <= w_we_n;
      r_oe_n     <= w_oe_n;
      r_ce_n     <= w_ce_n;
      r_wr_ack   <= w_wr_ack;
      r_rd_ack   <= w_rd_ack;
      r_rd_data  <= w_rd_data;
      r_rd_valid <= w_rd_valid;
      r_busy     <= w_busy;
    end
  end

  assign o_wr_ack     = r_wr_ack;
  assign o_rd_ack     = r_rd_ack;
  assign o_rd_data    = r_rd_data;
  assign o_rd_valid   = r_rd_valid;
  assign o_sram_addr  = r_addr;
  assign o_sram_wdata = r_wdata;
  assign o_sram_we_n  = r_we_n;
  assign o_sram_oe_n  = r_oe_n;
  assign o_sram_ce_n  = r_ce_n;
  assign o_busy       = r_busy;

`ifdef SRAM_ARB_STATS_EN
  logic        w_conflict;
  logic [15:0] r_conflicts;

  assign w_conflict = (r_state == S_IDLE) && i_wr_req && i_rd_req;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_conflicts <= '0;
    end else if (w_conflict && (r_conflicts != 16'hFFFF)) begin
      r_conflicts <= r_conflicts + 16'd1;
    end
  end

  assign o_conflicts = r_conflicts;
`endif

endmodule
